// File: rtl/pll_ce_multi.sv
// Multi-channel fractional clock-enable generator with runtime reprogramming and lock flag.
module pll_ce_multi #(
  parameter int unsigned     CHANNELS    = 2,
  parameter int unsigned     ACC_WIDTH   = 32,
  parameter int unsigned     LOCK_CYCLES = 1024,
  parameter longint unsigned RESET_INCR  = 64'd2147483648
) (
  input  logic                                                  refclk,
  input  logic                                                  rst,
  input  logic [CHANNELS-1:0]                                   enable,
  input  logic                                                  cfg_valid,
  output logic                                                  cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]    cfg_chan,
  input  logic [ACC_WIDTH-1:0]                                  cfg_incr,
  input  logic [ACC_WIDTH-1:0]                                  cfg_phase,
  output logic [CHANNELS-1:0]                                   outclk_ce,
  output logic                                                  locked
);

  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W  = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {SETTLE, LOCKED, APPLY} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  locked_d, ready_d;
  logic [CHAN_W-1:0]     hold_chan_q, hold_chan_d;
  logic [ACC_WIDTH-1:0]  hold_incr_q, hold_incr_d;
  logic [ACC_WIDTH-1:0]  hold_phase_q, hold_phase_d;
  logic                  apply_c;
  logic                  in_range_c;

  logic [ACC_WIDTH-1:0]  acc_q  [CHANNELS];
  logic [ACC_WIDTH-1:0]  incr_q [CHANNELS];
  logic [ACC_WIDTH:0]    sum_c  [CHANNELS];

  // Channel select is valid only when it names an existing channel.
  always_comb begin
    in_range_c = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (cfg_chan == CHAN_W'(i)) in_range_c = 1'b1;
    end
  end

  // Next-state logic for the settle/lock/apply sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    locked_d     = locked;
    ready_d      = cfg_ready;
    hold_chan_d  = hold_chan_q;
    hold_incr_d  = hold_incr_q;
    hold_phase_d = hold_phase_q;
    apply_c      = 1'b0;
    case (state_q)
      SETTLE: begin
        ready_d  = 1'b1;
        locked_d = 1'b0;
        if (cfg_valid && cfg_ready && in_range_c) begin
          state_d      = APPLY;
          ready_d      = 1'b0;
          hold_chan_d  = cfg_chan;
          hold_incr_d  = cfg_incr;
          hold_phase_d = cfg_phase;
        end else begin
          if (cnt_q == CNT_LOCK) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        ready_d  = 1'b1;
        locked_d = 1'b1;
        if (cfg_valid && cfg_ready && in_range_c) begin
          state_d      = APPLY;
          ready_d      = 1'b0;
          locked_d     = 1'b0;
          hold_chan_d  = cfg_chan;
          hold_incr_d  = cfg_incr;
          hold_phase_d = cfg_phase;
        end
      end
      APPLY: begin
        apply_c  = 1'b1;
        cnt_d    = '0;
        state_d  = SETTLE;
        ready_d  = 1'b1;
        locked_d = 1'b0;
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state, lock counter, handshake outputs and pending payload.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= SETTLE;
      cnt_q        <= '0;
      locked       <= 1'b0;
      cfg_ready    <= 1'b0;
      hold_chan_q  <= '0;
      hold_incr_q  <= '0;
      hold_phase_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      locked       <= locked_d;
      cfg_ready    <= ready_d;
      hold_chan_q  <= hold_chan_d;
      hold_incr_q  <= hold_incr_d;
      hold_phase_q <= hold_phase_d;
    end
  end

  // Per-channel accumulate with carry out.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      sum_c[i] = {1'b0, acc_q[i]} + {1'b0, incr_q[i]};
    end
  end

  // Phase accumulators: carry becomes the next-cycle enable pulse.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      outclk_ce <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        acc_q[i]  <= '0;
        incr_q[i] <= ACC_WIDTH'(RESET_INCR);
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (apply_c && (hold_chan_q == CHAN_W'(i))) begin
          incr_q[i]    <= hold_incr_q;
          acc_q[i]     <= hold_phase_q;
          outclk_ce[i] <= 1'b0;
        end else if (enable[i]) begin
          acc_q[i]     <= sum_c[i][ACC_WIDTH-1:0];
          outclk_ce[i] <= sum_c[i][ACC_WIDTH];
        end else begin
          outclk_ce[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_ce_multi.sv
// Scoreboard bench for pll_ce_multi: stimulus queues per-cycle expectations, monitor checks at negedge.
module tb_pll_ce_multi;

  logic       refclk = 1'b0;
  logic       rst;
  logic [1:0] enable;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_chan;
  logic [7:0] cfg_incr;
  logic [7:0] cfg_phase;
  logic [1:0] outclk_ce;
  logic       locked;

  // second instance with a 2-bit channel select so an out-of-range index exists
  logic [2:0] o_enable;
  logic       o_valid;
  logic       o_ready;
  logic [1:0] o_chan;
  logic [7:0] o_incr;
  logic [7:0] o_phase;
  logic [2:0] o_ce;
  logic       o_locked;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [1:0] ce;
    logic       lk;
    logic       rdy;
    logic       chk_oor;
    logic [2:0] ce_o;
    logic       lk_o;
    logic       rdy_o;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  pll_ce_multi #(.CHANNELS(2), .ACC_WIDTH(8), .LOCK_CYCLES(16), .RESET_INCR(64'd128)) dut (
    .refclk(refclk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_incr(cfg_incr), .cfg_phase(cfg_phase), .outclk_ce(outclk_ce),
    .locked(locked)
  );

  pll_ce_multi #(.CHANNELS(3), .ACC_WIDTH(8), .LOCK_CYCLES(16), .RESET_INCR(64'd128)) dut_oor (
    .refclk(refclk), .rst(rst), .enable(o_enable), .cfg_valid(o_valid), .cfg_ready(o_ready),
    .cfg_chan(o_chan), .cfg_incr(o_incr), .cfg_phase(o_phase), .outclk_ce(o_ce),
    .locked(o_locked)
  );

  always #5 refclk = ~refclk;

  // rising edges counted since the last reset release (frozen while in reset)
  always @(posedge refclk) if (!rst) cyc <= cyc + 1;

  function automatic void chk(string name, int k, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, k, got, want);
    end
  endfunction

  function automatic void push(int k, logic ce1, logic ce0, logic lk, logic rdy);
    exp_t x;
    x.cyc = k; x.ce = {ce1, ce0}; x.lk = lk; x.rdy = rdy;
    x.chk_oor = 1'b0; x.ce_o = 3'b000; x.lk_o = 1'b0; x.rdy_o = 1'b0;
    exp_q.push_back(x);
  endfunction

  function automatic void push_oor(int k, logic ce1, logic ce0, logic lk, logic rdy,
                                   logic [2:0] ce_o, logic lk_o, logic rdy_o);
    exp_t x;
    x.cyc = k; x.ce = {ce1, ce0}; x.lk = lk; x.rdy = rdy;
    x.chk_oor = 1'b1; x.ce_o = ce_o; x.lk_o = lk_o; x.rdy_o = rdy_o;
    exp_q.push_back(x);
  endfunction

  // monitor: compare every queued expectation due at this cycle
  always @(negedge refclk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_sample cyc=%0d got=%0d exp=%0d", cyc, cyc, e.cyc);
      end else begin
        chk("outclk_ce", cyc, int'(outclk_ce), int'(e.ce));
        chk("locked", cyc, int'(locked), int'(e.lk));
        chk("cfg_ready", cyc, int'(cfg_ready), int'(e.rdy));
        if (e.chk_oor) begin
          chk("oor_ce", cyc, int'(o_ce), int'(e.ce_o));
          chk("oor_locked", cyc, int'(o_locked), int'(e.lk_o));
          chk("oor_ready", cyc, int'(o_ready), int'(e.rdy_o));
        end
      end
    end
  end

  // advance to 1 time unit after rising edge number n
  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 5000) begin
      @(posedge refclk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      checks++;
      failures++;
      $display("FAIL at_cyc_timeout got=%0d exp=%0d", cyc, n);
    end
  endtask

  task automatic send(input logic [0:0] ch, input logic [7:0] inc, input logic [7:0] ph);
    cfg_chan  = ch;
    cfg_incr  = inc;
    cfg_phase = ph;
    cfg_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 2'b11; cfg_valid = 1'b0; cfg_chan = '0; cfg_incr = '0; cfg_phase = '0;
    o_enable = 3'b111; o_valid = 1'b0; o_chan = '0; o_incr = '0; o_phase = '0;

    // reset state, then incr=128 on both channels: pulses on even edges, lock at edge 16
    push(0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) push(k, k % 2 == 0, k % 2 == 0, k >= 16, 1'b1);
    repeat (3) @(posedge refclk);
    #1 rst = 1'b0;

    // chan0 incr=64 phase=0: accept at 21, apply at 22, pulses from 26 every 4
    at_cyc(20);
    for (int k = 21; k <= 40; k++)
      push(k, k % 2 == 0, (k >= 26) && ((k - 26) % 4 == 0), k >= 38, k != 21);
    send(1'b0, 8'd64, 8'd0);
    at_cyc(21);
    cfg_valid = 1'b0;

    // chan1 incr=64 phase=192: accept 41, apply 42, first pulse after edge 43
    at_cyc(40);
    for (int k = 41; k <= 60; k++)
      push(k, (k >= 43) && ((k - 43) % 4 == 0), k % 4 == 2, k >= 58, k != 41);
    send(1'b1, 8'd64, 8'd192);
    at_cyc(41);
    cfg_valid = 1'b0;

    // chan1 incr=0: silent for 300 cycles
    at_cyc(60);
    for (int k = 61; k <= 362; k++) push(k, 1'b0, k % 4 == 2, k >= 78, k != 61);
    send(1'b1, 8'd0, 8'd0);
    at_cyc(61);
    cfg_valid = 1'b0;

    // reconfig at lock count 10 then again at earliest edge; lock 17 after the last
    at_cyc(362);
    for (int k = 363; k <= 400; k++)
      push(k, (k >= 379) && (k % 2 == 1), k % 4 == 2, (k < 363) || (k >= 394),
           (k != 363) && (k != 375) && (k != 377));
    send(1'b1, 8'd0, 8'd0);
    at_cyc(363);
    cfg_valid = 1'b0;
    at_cyc(374);
    send(1'b1, 8'd0, 8'd0);
    at_cyc(375);
    send(1'b1, 8'd128, 8'd128);
    at_cyc(377);
    cfg_valid = 1'b0;

    // out-of-range channel on the 3-channel instance: accepted, no relock, no change
    at_cyc(400);
    for (int k = 401; k <= 410; k++)
      push_oor(k, k % 2 == 1, k % 4 == 2, 1'b1, 1'b1,
               (k % 2 == 0) ? 3'b111 : 3'b000, 1'b1, 1'b1);
    o_chan = 2'd3; o_incr = 8'd0; o_phase = 8'd0; o_valid = 1'b1;
    at_cyc(401);
    o_valid = 1'b0;

    // enable0 low for edges 412..416: pulses shift by 5, phase preserved
    at_cyc(410);
    for (int k = 411; k <= 440; k++) begin
      if (k >= 412 && k <= 416) push(k, k % 2 == 1, 1'b0, 1'b1, 1'b1);
      else if (k < 412)         push(k, k % 2 == 1, k % 4 == 2, 1'b1, 1'b1);
      else                      push(k, k % 2 == 1, k % 4 == 3, 1'b1, 1'b1);
    end
    at_cyc(411);
    enable[0] = 1'b0;
    at_cyc(416);
    enable[0] = 1'b1;

    // async reset during APPLY: outputs clear before any edge; pending config lost
    at_cyc(440);
    push(441, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 442; k <= 470; k++) push(k, k % 2 == 1, k % 2 == 1, k >= 457, 1'b1);
    send(1'b0, 8'd32, 8'd0);
    at_cyc(441);
    cfg_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge refclk);
    #1 rst = 1'b0;

    at_cyc(470);
    @(negedge refclk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_ce_multi.md
Name: pll_ce_multi

Overview:
- Parametrised, multi-channel successor to the fixed single-output clock block.
- Generates per-channel fractional clock-enable pulses from refclk using phase accumulators, so each output rate = f_refclk * incr / 2^ACC_WIDTH.
- Channels are runtime-reprogrammable through a valid/ready config port, with a per-channel start phase.
- A locked flag mimics PLL semantics for downstream reset sequencing. Sits between the board reference clock and the core's clock-enable consumers (CPU, PRC, audio).

Parameters:
- CHANNELS, 2, number of independent enable outputs (1..8).
- ACC_WIDTH, 32, accumulator/increment width in bits (8..32).
- LOCK_CYCLES, 1024, refclk cycles of config stability before locked asserts (>=2).
- RESET_INCR, 2147483648, increment loaded into every channel on reset (refclk/2).

Ports:
- refclk  in  1  sole clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  CHANNELS  per-channel run; low holds the accumulator and forces ce low.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; transfer occurs when cfg_valid && cfg_ready at a rising edge.
- cfg_chan  in  max(1,clog2(CHANNELS))  target channel; values >= CHANNELS are accepted and ignored (no state change, no relock).
- cfg_incr  in  ACC_WIDTH  new increment.
- cfg_phase  in  ACC_WIDTH  accumulator start value.
- outclk_ce  out  CHANNELS  registered one-cycle enable pulses.
- locked  out  1  high when all channels are stable.

Behaviour:
- Reset (async assert, sync release): every incr=RESET_INCR, acc=0; outclk_ce=0; locked=0; cfg_ready=0; lock counter=0; FSM=SETTLE.
- Accumulator, each edge with enable[i]=1 and no apply to channel i: {carry, acc} = acc + incr (ACC_WIDTH+1 bits); acc wraps mod 2^ACC_WIDTH; outclk_ce[i] <= carry.
  - Pulse appears in the cycle after the overflowing edge.
  - incr=0 gives no pulses.
  - incr=2^ACC_WIDTH-1 pulses on every cycle except one per 2^ACC_WIDTH cycles.
- enable[i]=0: acc held; outclk_ce[i] <= 0. Re-enable resumes from the held value.
- FSM states:
  - SETTLE: cfg_ready=1. Lock counter increments each cycle. At count LOCK_CYCLES-1, go to LOCKED and set locked=1 on the same edge.
  - LOCKED: cfg_ready=1, locked=1.
  - APPLY: single cycle; cfg_ready=0, locked=0. Loads incr[chan]=cfg_incr and acc[chan]=cfg_phase, outclk_ce[chan] <= 0, lock counter cleared. Goes to SETTLE next edge.
- A valid transfer in SETTLE or LOCKED (chan in range) moves the FSM to APPLY; locked drops on that same edge.
  - Payload is captured into holding registers at the transfer edge and applied in APPLY.
  - Other channels keep running.
- Reconfig during SETTLE restarts the lock count from 0, i.e. locked is asserted LOCK_CYCLES+1 cycles after the last accepted transfer.
- Back-to-back requests: cfg_ready is low in APPLY, so at most one transfer per 2 cycles.
- Mid-operation rst: immediate async clear of all state, including pending holding registers.
- Lock counter width is clog2(LOCK_CYCLES+1) and saturates; it never wraps.

Test Plan:
- Bench uses ACC_WIDTH=8, CHANNELS=2, LOCK_CYCLES=16, RESET_INCR=128.
- Reset, enable=2'b11: outclk_ce toggles with period 2 on both channels. locked rises on the 16th rising edge after rst release and stays high.
- In LOCKED, cfg chan0 incr=64 phase=0: cfg_ready low for exactly 1 cycle and locked falls at the accept edge. ce0 then pulses every 4 cycles, first pulse 4 cycles after APPLY. ce1 is undisturbed with period 2. locked returns 17 cycles after the accept edge.
- cfg chan1 incr=64 phase=192: first ce1 pulse in the cycle after the first post-APPLY edge, then every 4 cycles. cfg incr=0 on chan1: ce1 stays 0 for 300 cycles.
- Accepted cfg at lock count 10, then a second accepted cfg at the earliest allowed edge: locked stays 0 until 17 cycles after the second accept. A request to cfg_chan=3 (out of range) is accepted with no relock and no channel change.
- enable0 dropped for 5 cycles mid-period with incr=64: no ce0 pulses while low; pulse spacing resumes with the pre-drop phase preserved.
- rst asserted asynchronously mid-APPLY: outputs clear immediately without a clock edge. After release both channels run at incr=128 and the pending config is lost.
